// File: rtl/fifo_pkg.sv
// Shared constants and occupancy-state encoding for the FIFO reader and its skid buffer.
package fifo_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 16;

   // Encoded value equals the number of words held downstream of the source FIFO.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_state_t;
endpackage

// File: rtl/fifo_reader_skid.sv
// Output register plus one skid entry; words arriving on cap are presented in order on data/valid.
// Capture lands in the output register when it is free or popping, else in skid; data/valid hold while stalled.
module fifo_reader_skid
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cap,
   input  logic [WIDTH-1:0] cap_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic [1:0]       occ
);

   occ_state_t       state;
   logic [WIDTH-1:0] skid;
   logic             pop;

   assign pop = valid & ready;
   assign occ = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= EMPTY;
         valid <= 1'b0;
         data  <= '0;
         skid  <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (cap) begin
                  data  <= cap_data;
                  valid <= 1'b1;
                  state <= ONE;
               end
            end
            ONE: begin
               if (cap && pop) begin
                  data <= cap_data;
               end else if (cap) begin
                  skid  <= cap_data;
                  state <= TWO;
               end else if (pop) begin
                  valid <= 1'b0;
                  state <= EMPTY;
               end
            end
            TWO: begin
               // A capture without a pop cannot occur here: the read issue logic never over-commits.
               if (pop) begin
                  data <= skid;
                  if (cap) skid  <= cap_data;
                  else     state <= ONE;
               end
            end
            default: begin
               state <= EMPTY;
               valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/fifo_reader.sv
// Drains a source FIFO into a valid/ready stream; read-to-valid latency 2 cycles, 1 word/cycle sustained.
// Reads only while the 2-entry buffer can absorb them; optional rd_count pop counter with FIFO_READER_CNT_EN.
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty,
   output logic             fifo_read,
   input  logic [WIDTH-1:0] fifo_data_out,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
`ifdef FIFO_READER_CNT_EN
   ,
   output logic [$clog2(DEPTH):0] rd_count
`endif
);

   if (DEPTH < 1) begin : g_depth_chk
      $error("fifo_reader: DEPTH must be at least 1");
   end

   logic       inflight;
   logic       pop;
   logic [1:0] occ;

   assign pop = out_valid & out_ready;

   // Issue a read only if, counting the word already in flight, the buffer still has room after this edge.
   assign fifo_read = rst & ~fifo_empty &
                      (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) inflight <= 1'b0;
      else      inflight <= fifo_read;
   end

`ifdef FIFO_READER_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)     rd_count <= '0;
      else if (pop) rd_count <= rd_count + 1'b1;
   end
`endif

   fifo_reader_skid #(
      .WIDTH(WIDTH)
   ) u_skid (
      .clk      (clk),
      .rst      (rst),
      .cap      (inflight),
      .cap_data (fifo_data_out),
      .ready    (out_ready),
      .data     (out_data),
      .valid    (out_valid),
      .occ      (occ)
   );

endmodule

// File: tb/tb_fifo_reader.sv
// Randomized bench for fifo_reader against a queue-based reference of the source FIFO and 2-word buffer.
module tb_fifo_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        fifo_empty;
   logic        fifo_read;
   logic [15:0] fifo_data_out;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
`ifdef FIFO_READER_CNT_EN
   logic [4:0]  rd_count;
`endif

   always #5 clk = ~clk;

   fifo_reader #(.WIDTH(16), .DEPTH(16)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_empty    (fifo_empty),
      .fifo_read     (fifo_read),
      .fifo_data_out (fifo_data_out),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
`ifdef FIFO_READER_CNT_EN
      ,
      .rd_count      (rd_count)
`endif
   );

   int checks = 0;
   int errors = 0;

   logic [15:0] src[$];    // source FIFO contents
   logic [15:0] order[$];  // every word loaded, in the order it must come out
   logic [15:0] held[$];   // words the reader should be holding
   bit          infl_m;
   logic [15:0] infl_w;
   int          pops_m;
   int          cycle, reads_n, valid_n, cur_run, max_run, first_rd, first_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
      end
   endtask

   task automatic load(input logic [15:0] w);
      src.push_back(w);
      order.push_back(w);
   endtask

   task automatic clear_stats();
      reads_n = 0; valid_n = 0; cur_run = 0; max_run = 0;
      first_rd = -1; first_v = -1;
   endtask

   task automatic step(input bit rdy);
      bit exp_v, pop, exp_rd;
      @(negedge clk);
      out_ready     = rdy;
      fifo_empty    = (src.size() == 0);
      fifo_data_out = infl_m ? infl_w : 16'($urandom);
      #1;
      exp_v  = (held.size() > 0);
      pop    = exp_v && rdy;
      exp_rd = !fifo_empty && (int'(held.size()) + int'(infl_m) - int'(pop) < 2);
      chk("fifo_read", 32'(fifo_read), 32'(exp_rd));
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) chk("out_data", 32'(out_data), 32'(held[0]));
      if (out_valid && rdy) begin
         if (order.size() == 0) chk("spurious_word", 32'(out_valid), 32'd0);
         else                   chk("order", 32'(out_data), 32'(order.pop_front()));
      end
`ifdef FIFO_READER_CNT_EN
      chk("rd_count", 32'(rd_count), 32'(pops_m % 32));
`endif
      if (fifo_read) begin
         reads_n++;
         if (first_rd < 0) first_rd = cycle;
      end
      if (out_valid) begin
         valid_n++;
         cur_run++;
         if (cur_run > max_run) max_run = cur_run;
         if (first_v < 0) first_v = cycle;
      end else begin
         cur_run = 0;
      end
      if (pop) begin
         void'(held.pop_front());
         pops_m++;
      end
      if (infl_m) begin
         held.push_back(infl_w);
         if (held.size() > 2) chk("overflow_capture", 32'(held.size()), 32'd2);
      end
      infl_m = fifo_read;
      if (fifo_read && src.size() > 0) infl_w = src.pop_front();
      cycle++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      fifo_empty = 1'b0;
      out_ready  = 1'b1;
      rst        = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_fifo_read", 32'(fifo_read), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
`ifdef FIFO_READER_CNT_EN
      chk("rst_rd_count",  32'(rd_count),  32'd0);
`endif
      @(negedge clk);
      #1;
      chk("rst_next_valid", 32'(out_valid), 32'd0);
      chk("rst_next_read",  32'(fifo_read), 32'd0);
      src.delete(); order.delete(); held.delete();
      infl_m     = 1'b0;
      pops_m     = 0;
      fifo_empty = 1'b1;
      rst        = 1'b1;
   endtask

   initial begin
      rst = 1'b0; fifo_empty = 1'b0; out_ready = 1'b0; fifo_data_out = '0;
      infl_m = 1'b0; infl_w = '0; pops_m = 0; cycle = 0;
      clear_stats();
      repeat (2) @(negedge clk);
      #1;
      chk("init_out_valid", 32'(out_valid), 32'd0);
      chk("init_out_data",  32'(out_data),  32'd0);
      chk("init_fifo_read", 32'(fifo_read), 32'd0);
      fifo_empty = 1'b1;
      rst = 1'b1;

      // single word
      clear_stats();
      load(16'hA5A5);
      repeat (6) step(1'b1);
      chk("single_reads", 32'(reads_n), 32'd1);
      chk("single_latency", 32'(first_v - first_rd), 32'd2);

      // streaming 0..15 from a clean counter
      do_reset();
      clear_stats();
      for (int i = 0; i < 16; i++) load(16'(i));
      repeat (22) step(1'b1);
      chk("stream_run", 32'(max_run), 32'd16);
`ifdef FIFO_READER_CNT_EN
      chk("stream_rd_count", 32'(rd_count), 32'd16);
`endif

      // backpressure with four queued words
      clear_stats();
      for (int i = 0; i < 4; i++) load(16'(i));
      repeat (8) step(1'b0);
      chk("bp_reads", 32'(reads_n), 32'd2);
      chk("bp_hold_data", 32'(out_data), 32'd0);
      chk("bp_occ", 32'(u_dut.occ), 32'd2);
      clear_stats();
      repeat (8) step(1'b1);
      chk("bp_release_run", 32'(max_run), 32'd4);
      chk("bp_drained", 32'(order.size()), 32'd0);

      // empty source with toggling ready
      clear_stats();
      for (int i = 0; i < 20; i++) step(1'(i));
      chk("empty_reads", 32'(reads_n), 32'd0);
      chk("empty_valids", 32'(valid_n), 32'd0);

      // alternating ready: pop, capture and read coincide at occ 1
      for (int i = 0; i < 8; i++) load(16'($urandom));
      for (int i = 0; i < 24; i++) step(1'(i));
      chk("alt_drained", 32'(order.size()), 32'd0);

      // random arrivals and random backpressure
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 2) == 0) load(16'($urandom));
         step($urandom_range(0, 3) != 0);
      end
      repeat (12) step(1'b1);
      chk("rand_drained", 32'(order.size()), 32'd0);

      // reset while holding two words with a read pending
      for (int i = 0; i < 4; i++) load(16'($urandom));
      repeat (6) step(1'b0);
      chk("pre_reset_occ", 32'(u_dut.occ), 32'd2);
      do_reset();
      load(16'h3C3C);
      clear_stats();
      repeat (5) step(1'b1);
      chk("post_reset_first_read", 32'(first_rd), 32'(cycle - 5));
      chk("post_reset_drained", 32'(order.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, depth of the source FIFO; used only to size rd_count and by checkers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port fifo_empty  input  1  source FIFO empty flag.
REQ-006 SHALL have port fifo_read  output  1  read strobe to the source FIFO.
REQ-007 SHALL have port fifo_data_out  input  WIDTH  source FIFO read data, valid in the cycle after a fifo_read cycle.
REQ-008 SHALL have port out_data  output  WIDTH  word presented downstream.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer = out_valid & out_ready at posedge.

Function
REQ-011 SHALL drain the source FIFO and present its words downstream in FIFO order, with no loss or duplication.
REQ-012 SHALL hold up to 2 words internally: an output register plus one skid entry; occ = 0..2.
REQ-013 SHALL track inflight = 1 in the cycle after any fifo_read cycle, when fifo_data_out must be captured.
REQ-014 SHALL drive fifo_read = !fifo_empty & (occ + inflight - pop < 2), where pop = out_valid & out_ready, combinational.
REQ-015 SHALL never assert fifo_read while fifo_empty = 1, and never assert it while reset is active.
REQ-016 SHALL capture fifo_data_out at the posedge ending every inflight cycle: into the output register if it is empty or popping, otherwise into the skid entry.
REQ-017 SHALL, on a pop with the skid entry occupied, move the skid word to the output register in the same edge.
REQ-018 SHALL use the state machine EMPTY (occ 0), ONE (occ 1), TWO (occ 2), with next occ = occ + inflight - pop. Capture and pop in the same edge keep occ unchanged.
REQ-019 SHALL have latency: fifo_read in cycle N -> out_valid = 1 with that word in cycle N+2, when the output register is free.
REQ-020 SHALL sustain 1 word/cycle when fifo_empty = 0 and out_ready = 1 continuously.
REQ-021 SHALL hold out_data and out_valid stable while out_valid & !out_ready.
REQ-022 SHALL keep out_valid = 1 iff occ >= 1; occ must never exceed 2. An attempted third capture is a design error, flagged by the bench.

Reset
REQ-023 SHALL, on rst low, asynchronously force occ = 0, inflight = 0, out_valid = 0, out_data = 0, fifo_read = 0, and rd_count = 0 when present.
REQ-024 SHALL discard a word in flight and held words when reset asserts mid-operation; after rst rises, the first fifo_read may occur in the first cycle.

Configuration
REQ-025 SHALL, with macro FIFO_READER_CNT_EN defined, add output rd_count, width $clog2(DEPTH)+1, incremented on each pop and wrapping modulo 2^width.
REQ-026 SHALL, without FIFO_READER_CNT_EN, omit port rd_count and its logic; all other behaviour is identical.

Structure
REQ-027 SHALL take the state enum (EMPTY/ONE/TWO) and the default WIDTH/DEPTH constants from the shared package fifo_pkg.
REQ-028 SHALL implement the 2-entry output/skid buffer as sub-module fifo_reader_skid; fifo_reader holds the read-issue logic, inflight tracking and the counter.

Verification
REQ-029 SHALL cover reset: rst low mid-transfer with occ = 2 -> next cycle out_valid = 0, fifo_read = 0, out_data = 0, rd_count = 0.
REQ-030 SHALL cover single word: FIFO loaded with 16'hA5A5, out_ready = 1 -> fifo_read for 1 cycle, out_valid with A5A5 two cycles later, then fifo_read stays 0 while fifo_empty = 1.
REQ-031 SHALL cover streaming: 16 words 0..15, out_ready = 1 -> out_valid high 16 consecutive cycles, data 0..15 in order, rd_count = 16 (wraps per width).
REQ-032 SHALL cover backpressure: out_ready = 0 with 4 words queued -> fifo_read stops after 2 reads, out_data holds word 0, occ = 2. Raising out_ready -> words 0..3 in order, with no gap after the first.
REQ-033 SHALL cover an empty FIFO: fifo_empty = 1 for 20 cycles with out_ready toggling -> fifo_read = 0 and out_valid = 0 throughout.
REQ-034 SHALL cover simultaneous events: pop, capture and fifo_read in one edge at occ = 1 -> occ stays 1 and ordering is preserved across 8 alternating-ready words.
